// File: rtl/m_wb_initiator.sv
// m_wb_initiator: Wishbone classic single-transfer bus master.
// It takes commands on a valid/ready port and runs one Wishbone access per command.
// It returns each result on a valid/ready response port.
// An access is aborted once STB_O has been high for 2**TMOWIDTH-1 cycles.
// Optional feature macro: M_WB_INITIATOR_LATENCY_EN.
//   - Defined: rsp_lat carries the measured STB-to-ACK cycle count.
//   - Undefined: rsp_lat is 0 on success and all ones on timeout.
module m_wb_initiator #(
    parameter int TMOWIDTH = 8,
    parameter int ADRWIDTH = 32
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    // command port
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADRWIDTH-1:0] cmd_adr,
    input  logic [31:0]         cmd_dat,
    input  logic [3:0]          cmd_sel,
    // response port
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_dat,
    output logic                rsp_err,
    output logic [TMOWIDTH-1:0] rsp_lat,
    // Wishbone initiator side
    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O,
    output logic [ADRWIDTH-1:0] ADR_O,
    output logic [31:0]         DAT_O,
    output logic [3:0]          SEL_O,
    input  logic                ACK_I,
    input  logic [31:0]         DAT_I
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    localparam logic [TMOWIDTH-1:0] CNT_ONE  = TMOWIDTH'(1);
    localparam logic [TMOWIDTH-1:0] CNT_ONES = '1;
    // Counter value in the last permitted STB cycle (2**TMOWIDTH-2).
    localparam logic [TMOWIDTH-1:0] CNT_LAST = CNT_ONES - CNT_ONE;

    state_t                state_q;
    logic                  bus_q;      // drives both CYC_O and STB_O
    logic                  we_q;
    logic [ADRWIDTH-1:0]   adr_q;
    logic [31:0]           dat_q;
    logic [3:0]            sel_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_dat_q;
    logic                  rsp_err_q;
    logic [TMOWIDTH-1:0]   rsp_lat_q;
    logic [TMOWIDTH-1:0]   cnt_q;
    logic [TMOWIDTH-1:0]   cnt_d;
    logic [TMOWIDTH-1:0]   lat_ok;

    // Saturating increment; the counter must never wrap back to zero.
    assign cnt_d = (cnt_q == CNT_ONES) ? cnt_q : cnt_q + CNT_ONE;

`ifdef M_WB_INITIATOR_LATENCY_EN
    assign lat_ok = cnt_q;
`else
    assign lat_ok = '0;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_lat   = rsp_lat_q;
    assign CYC_O     = bus_q;
    assign STB_O     = bus_q;
    assign WE_O      = we_q;
    assign ADR_O     = adr_q;
    assign DAT_O     = dat_q;
    assign SEL_O     = sel_q;

    // Access sequencer: IDLE accepts a command, BUS waits for ACK or timeout,
    // RSP holds the result until the consumer takes it.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= S_IDLE;
            bus_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_lat_q   <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        we_q    <= cmd_we;
                        adr_q   <= cmd_adr;
                        dat_q   <= cmd_dat;
                        sel_q   <= cmd_sel;
                        bus_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (ACK_I) begin
                        // ACK in the final cycle still beats the timeout.
                        bus_q       <= 1'b0;
                        rsp_dat_q   <= we_q ? 32'h0 : DAT_I;
                        rsp_err_q   <= 1'b0;
                        rsp_lat_q   <= lat_ok;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_LAST) begin
                            bus_q       <= 1'b0;
                            rsp_dat_q   <= 32'h0;
                            rsp_err_q   <= 1'b1;
                            rsp_lat_q   <= CNT_ONES;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RSP;
                        end
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    bus_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_wb_initiator.sv
// Testbench for m_wb_initiator: a transaction-level reference model,
// a per-cycle compare process, directed scenarios and randomized accesses.
module tb_m_wb_initiator;

    localparam int TW   = 4;
    localparam int AW   = 32;
    localparam int MAXC = (1 << TW) - 1;   // STB cycles before an abort
`ifdef M_WB_INITIATOR_LATENCY_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [31:0]   cmd_dat = '0;
    logic [3:0]    cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_dat;
    logic          rsp_err;
    logic [TW-1:0] rsp_lat;
    logic          CYC_O, STB_O, WE_O;
    logic [AW-1:0] ADR_O;
    logic [31:0]   DAT_O;
    logic [3:0]    SEL_O;
    logic          ACK_I;
    logic [31:0]   DAT_I;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Responder model: ACKs when STB has been high for lat_cfg earlier cycles.
    int          lat_cfg   = 0;
    logic [31:0] rd_cfg    = '0;
    bit          force_ack = 1'b0;
    int          stb_cnt   = 0;
    int          stb_seen  = 0;

    assign ACK_I = ((STB_O === 1'b1) && (stb_cnt == lat_cfg)) || force_ack;
    assign DAT_I = rd_cfg;

    always #5 CLK_I = ~CLK_I;

    m_wb_initiator #(.TMOWIDTH(TW), .ADRWIDTH(AW)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_lat(rsp_lat),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O),
        .DAT_O(DAT_O), .SEL_O(SEL_O), .ACK_I(ACK_I), .DAT_I(DAT_I)
    );

    always @(posedge CLK_I) stb_cnt <= (STB_O === 1'b1) ? stb_cnt + 1 : 0;

    // Number of STB cycles of the most recently accepted access.
    always @(negedge CLK_I)
        if (cmd_valid && cmd_ready === 1'b1) stb_seen <= 0;
        else if (STB_O === 1'b1)             stb_seen <= stb_seen + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted access occupies a known number of STB
    // cycles (ACK latency + 1, or the abort length), then a response is
    // presented until consumed.
    int            m_left = 0;
    bit            m_rsp  = 1'b0;
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_adr  = '0;
    logic [31:0]   m_dat  = '0;
    logic [3:0]    m_sel  = '0;
    logic [31:0]   m_edat = '0, p_dat = '0;
    logic          m_eerr = 1'b0, p_err = 1'b0;
    logic [TW-1:0] m_elat = '0, p_lat = '0;

    always @(posedge CLK_I) begin
        if (RST_I) begin
            m_left <= 0;  m_rsp <= 1'b0;
            m_we <= 1'b0; m_adr <= '0; m_dat <= '0; m_sel <= '0;
            m_edat <= '0; m_eerr <= 1'b0; m_elat <= '0;
        end else if (m_rsp) begin
            if (rsp_ready) m_rsp <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_rsp <= 1'b1; m_edat <= p_dat; m_eerr <= p_err; m_elat <= p_lat;
            end
        end else if (cmd_valid) begin
            m_we <= cmd_we; m_adr <= cmd_adr; m_dat <= cmd_dat; m_sel <= cmd_sel;
            if (lat_cfg < MAXC) begin
                m_left <= lat_cfg + 1;
                p_err  <= 1'b0;
                p_dat  <= cmd_we ? 32'h0 : rd_cfg;
                p_lat  <= LAT_EN ? TW'(lat_cfg) : '0;
            end else begin
                m_left <= MAXC;
                p_err  <= 1'b1;
                p_dat  <= 32'h0;
                p_lat  <= '1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK_I) begin
        if (cmp_en) begin
            chk("cmd_ready", cmd_ready, (!m_rsp && m_left == 0));
            chk("CYC_O", CYC_O, (m_left > 0));
            chk("STB_O", STB_O, (m_left > 0));
            chk("WE_O", WE_O, m_we);
            chk("ADR_O", ADR_O, m_adr);
            chk("DAT_O", DAT_O, m_dat);
            chk("SEL_O", SEL_O, m_sel);
            chk("rsp_valid", rsp_valid, m_rsp);
            chk("rsp_dat", rsp_dat, m_edat);
            chk("rsp_err", rsp_err, m_eerr);
            chk("rsp_lat", rsp_lat, m_elat);
        end
    end

    task automatic send_cmd(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int lat, input logic [31:0] rd);
        bit ok = 1'b0;
        lat_cfg = lat; rd_cfg = rd;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK_I);
            if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
        end
        chk("accept_wait", ok, 1'b1);
        @(posedge CLK_I); #1;
        cmd_valid = 1'b0;
        // Scramble the idle command bus; it must not reach the Wishbone side.
        cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    endtask

    task automatic get_rsp(input int hold, output logic [31:0] d, output logic e,
                           output logic [TW-1:0] l);
        bit ok = 1'b0;
        rsp_ready = (hold == 0);
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK_I);
            if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
        end
        chk("rsp_wait", ok, 1'b1);
        d = rsp_dat; e = rsp_err; l = rsp_lat;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK_I); #1;
            force_ack = (i == 0);      // stray ACK while a response is pending
        end
        force_ack = 1'b0;
        rsp_ready = 1'b1;
        @(posedge CLK_I); #1;
    endtask

    task automatic idle_ack();
        force_ack = 1'b1;
        @(posedge CLK_I); #1;
        force_ack = 1'b0;
        @(posedge CLK_I); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   d;
        logic          e;
        logic [TW-1:0] l;

        // Reset state
        repeat (3) @(posedge CLK_I);
        #1 RST_I = 1'b0;
        cmp_en = 1'b1;
        @(negedge CLK_I);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_stb", STB_O, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_adr", ADR_O, 32'h0);
        chk("rst_rsp_lat", rsp_lat, '0);
        @(posedge CLK_I); #1;

        // Write with a combinational-ACK responder
        send_cmd(1'b1, 32'h6000_0004, 32'h0000_2305, 4'hF, 0, 32'h1234_5678);
        get_rsp(0, d, e, l);
        chk("wr_stb_cycles", stb_seen, 1);
        chk("wr_rsp_dat", d, 32'h0);
        chk("wr_rsp_err", e, 1'b0);
        chk("wr_rsp_lat", l, '0);
        chk("wr_dat_o", DAT_O, 32'h0000_2305);
        chk("wr_we_o", WE_O, 1'b1);

        // Read, latency 5
        send_cmd(1'b0, 32'h6000_0008, 32'h0, 4'hF, 5, 32'hDEAD_BEEF);
        get_rsp(0, d, e, l);
        chk("rd5_stb_cycles", stb_seen, 6);
        chk("rd5_rsp_dat", d, 32'hDEAD_BEEF);
        chk("rd5_rsp_lat", l, LAT_EN ? 4'd5 : 4'd0);

        // No responder: timeout
        send_cmd(1'b0, 32'h7000_0000, 32'h0, 4'hF, 1000, 32'hCAFE_F00D);
        get_rsp(0, d, e, l);
        chk("tmo_stb_cycles", stb_seen, 15);
        chk("tmo_rsp_err", e, 1'b1);
        chk("tmo_rsp_dat", d, 32'h0);
        chk("tmo_rsp_lat", l, 4'hF);

        // ACK in the very last permitted cycle wins over the timeout
        send_cmd(1'b0, 32'h7000_0010, 32'h0, 4'h3, 14, 32'h0BAD_C0DE);
        get_rsp(0, d, e, l);
        chk("edge_stb_cycles", stb_seen, 15);
        chk("edge_rsp_err", e, 1'b0);
        chk("edge_rsp_dat", d, 32'h0BAD_C0DE);
        chk("edge_rsp_lat", l, LAT_EN ? 4'd14 : 4'd0);

        // Response held for 10 cycles; a second command waits
        send_cmd(1'b0, 32'h6000_0010, 32'h0, 4'hF, 2, 32'hA5A5_0001);
        rsp_ready = 1'b0;
        for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) @(negedge CLK_I);
        chk("hold_rsp_valid", rsp_valid, 1'b1);
        @(posedge CLK_I); #1;
        cmd_we = 1'b1; cmd_adr = 32'h6000_0020; cmd_dat = 32'h5555_AAAA; cmd_sel = 4'h5;
        lat_cfg = 1; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK_I);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_rsp_dat", rsp_dat, 32'hA5A5_0001);
            @(posedge CLK_I); #1;
        end
        rsp_ready = 1'b1;
        @(posedge CLK_I); #1;
        rsp_ready = 1'b0;
        @(negedge CLK_I);
        chk("hold_cmd_ready_after", cmd_ready, 1'b1);
        @(posedge CLK_I); #1;
        cmd_valid = 1'b0;
        get_rsp(0, d, e, l);
        chk("hold2_stb_cycles", stb_seen, 2);
        chk("hold2_rsp_dat", d, 32'h0);

        // Reset on the 3rd STB cycle of a latency-8 read
        send_cmd(1'b0, 32'h6000_0030, 32'h0, 4'hF, 8, 32'h1111_2222);
        @(posedge CLK_I); #1;
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
        @(negedge CLK_I);
        chk("rstmid_stb", STB_O, 1'b0);
        chk("rstmid_cyc", CYC_O, 1'b0);
        chk("rstmid_rsp_valid", rsp_valid, 1'b0);
        chk("rstmid_cmd_ready", cmd_ready, 1'b1);
        @(posedge CLK_I); #1;
        force_ack = 1'b1;
        repeat (6) @(posedge CLK_I);
        #1 force_ack = 1'b0;
        @(negedge CLK_I);
        chk("rstmid_late_ack", rsp_valid, 1'b0);
        @(posedge CLK_I); #1;

        // Stray ACK pulses in IDLE (RSP pulses happen inside get_rsp holds)
        idle_ack();
        idle_ack();

        // Randomized accesses
        for (int t = 0; t < 40; t++) begin
            int r, lat;
            r = $urandom_range(0, 9);
            if (r < 6)      lat = $urandom_range(0, 4);
            else if (r < 9) lat = $urandom_range(5, 15);
            else            lat = 200;
            send_cmd(1'($urandom), $urandom, $urandom, 4'($urandom), lat, $urandom);
            get_rsp($urandom_range(0, 3), d, e, l);
            if ($urandom_range(0, 3) == 0) idle_ack();
        end

        repeat (3) @(posedge CLK_I);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
